// File: rtl/regfile_access_ctrl_if.sv
// regfile_access_ctrl_if: core request/response and register-file port bundle
interface regfile_access_ctrl_if #(parameter int ADDR_W = 3, parameter int DATA_W = 8);
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rs1_addr_in;
  logic [ADDR_W-1:0] rs2_addr_in;
  logic              rd_resp_valid;
  logic [DATA_W-1:0] rs1_out;
  logic [DATA_W-1:0] rs2_out;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [2*DATA_W-1:0] wb_data;
  logic              wb_wide;
  logic              wb_done;
  logic [ADDR_W-1:0] rf_rs1_addr;
  logic [ADDR_W-1:0] rf_rs2_addr;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              rf_r_w;
  logic              rf_input_length;
  logic [DATA_W-1:0] rf_rs1_data;
  logic [DATA_W-1:0] rf_rs2_data;
  modport master (
    output rd_req_valid, rs1_addr_in, rs2_addr_in, wb_valid, wb_addr, wb_data, wb_wide,
           rf_rs1_data, rf_rs2_data,
    input  rd_req_ready, rd_resp_valid, rs1_out, rs2_out, wb_ready, wb_done,
           rf_rs1_addr, rf_rs2_addr, rf_rd_addr, rf_rd_data, rf_r_w, rf_input_length
  );
  modport slave (
    input  rd_req_valid, rs1_addr_in, rs2_addr_in, wb_valid, wb_addr, wb_data, wb_wide,
           rf_rs1_data, rf_rs2_data,
    output rd_req_ready, rd_resp_valid, rs1_out, rs2_out, wb_ready, wb_done,
           rf_rs1_addr, rf_rs2_addr, rf_rd_addr, rf_rd_data, rf_r_w, rf_input_length
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: sequences operand reads and byte-split writebacks onto a level-sensitive register file
module regfile_access_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic reset,
  regfile_access_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, WSETUP, WSTROBE, WHOLD} state_t;
  state_t state, state_n;
  logic pend, pend_n, resp_n, done_n, wb_acc, rd_acc;
  logic [ADDR_W-1:0] pend_addr, pend_addr_n, rd_addr_n, rs1_addr_n, rs2_addr_n;
  logic [DATA_W-1:0] pend_data, pend_data_n, rd_data_n;
  assign bus.wb_ready = state == IDLE && reset;
  assign bus.rd_req_ready = bus.wb_ready && !bus.wb_valid;
  assign bus.rf_input_length = 1'b0;
  assign wb_acc = bus.wb_valid && bus.wb_ready;
  assign rd_acc = bus.rd_req_valid && bus.rd_req_ready;
  always_comb begin
    state_n = state;
    pend_n = pend;
    pend_addr_n = pend_addr;
    pend_data_n = pend_data;
    rd_addr_n = bus.rf_rd_addr;
    rd_data_n = bus.rf_rd_data;
    rs1_addr_n = bus.rf_rs1_addr;
    rs2_addr_n = bus.rf_rs2_addr;
    resp_n = 1'b0;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        if (wb_acc) begin
          state_n = WSETUP;
          rd_addr_n = bus.wb_addr;
          rd_data_n = bus.wb_wide ? bus.wb_data[2*DATA_W-1:DATA_W] : bus.wb_data[DATA_W-1:0];
          pend_n = bus.wb_wide;
          pend_addr_n = bus.wb_addr + ADDR_W'(1);
          pend_data_n = bus.wb_data[DATA_W-1:0];
        end else if (rd_acc) begin
          state_n = RD;
          rs1_addr_n = bus.rs1_addr_in;
          rs2_addr_n = bus.rs2_addr_in;
        end
      end
      RD: begin
        state_n = IDLE;
        resp_n = 1'b1;
      end
      WSETUP: state_n = WSTROBE;
      WSTROBE: state_n = WHOLD;
      WHOLD: begin
        state_n = pend ? WSETUP : IDLE;
        done_n = !pend;
        rd_addr_n = pend ? pend_addr : bus.rf_rd_addr;
        rd_data_n = pend ? pend_data : bus.rf_rd_data;
        pend_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  // r_w is registered from the next state so the strobe never glitches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pend <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      bus.rf_rs1_addr <= '0;
      bus.rf_rs2_addr <= '0;
      bus.rf_rd_addr <= '0;
      bus.rf_rd_data <= '0;
      bus.rf_r_w <= 1'b1;
      bus.rs1_out <= '0;
      bus.rs2_out <= '0;
      bus.rd_resp_valid <= 1'b0;
      bus.wb_done <= 1'b0;
    end else begin
      state <= state_n;
      pend <= pend_n;
      pend_addr <= pend_addr_n;
      pend_data <= pend_data_n;
      bus.rf_rs1_addr <= rs1_addr_n;
      bus.rf_rs2_addr <= rs2_addr_n;
      bus.rf_rd_addr <= rd_addr_n;
      bus.rf_rd_data <= rd_data_n;
      bus.rf_r_w <= state_n != WSTROBE;
      bus.rs1_out <= state == RD ? bus.rf_rs1_data : bus.rs1_out;
      bus.rs2_out <= state == RD ? bus.rf_rs2_data : bus.rs2_out;
      bus.rd_resp_valid <= resp_n;
      bus.wb_done <= done_n;
    end
  end
endmodule
